// File: rtl/ssp_uart_cfg_seq.sv
// ssp_uart_cfg_seq: queues register read/write commands and frames each one on the SSP_UART slave port, returning one response per command
module ssp_uart_cfg_seq #(
  parameter int CLK_DIV = 2,
  parameter int DEPTH   = 4
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        Cmd_Vld,
  output logic        Cmd_Rdy,
  input  logic [2:0]  Cmd_RA,
  input  logic        Cmd_WnR,
  input  logic [11:0] Cmd_DI,
  output logic        SSP_SSEL,
  output logic        SSP_SCK,
  output logic [2:0]  SSP_RA,
  output logic        SSP_WnR,
  output logic        SSP_En,
  output logic        SSP_EOC,
  output logic [11:0] SSP_DI,
  input  logic [11:0] SSP_DO,
  output logic        Rsp_Vld,
  output logic [2:0]  Rsp_RA,
  output logic        Rsp_WnR,
  output logic [11:0] Rsp_DO,
  output logic        Busy
);
  localparam int BP = 2 * CLK_DIV;
  localparam int PW = (BP > 1) ? $clog2(BP) : 1;
  localparam int AW = $clog2(DEPTH);
  localparam logic [PW-1:0] PH_LAST = PW'(BP - 1);
  localparam logic [PW-1:0] PH_HI   = PW'(CLK_DIV);
  localparam logic [AW:0]   FULL    = (AW + 1)'(DEPTH);
  localparam logic [2:0] S_IDLE = 3'd0, S_SETUP = 3'd1, S_XFER = 3'd2, S_HOLD = 3'd3, S_GAP = 3'd4;
  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          r_rdy;
  logic [2:0]    r_st;
  logic [PW-1:0] r_ph;
  logic [3:0]    r_bit;
  logic [2:0]    r_ra;
  logic          r_wnr;
  logic [11:0]   r_di, r_do;
  logic          w_push, w_pop, w_ph_end, w_x_end, w_sel;
  logic [AW:0]   w_cnt_nx;
  logic [2:0]    w_st_nx;
  always_comb begin
    w_push   = Cmd_Vld & r_rdy;
    w_pop    = (r_st == S_IDLE) & (r_cnt != '0);
    w_ph_end = r_ph == PH_LAST;
    w_x_end  = (r_st == S_XFER) & w_ph_end & (r_bit == 4'd11);
    w_cnt_nx = r_cnt + (AW + 1)'(w_push) - (AW + 1)'(w_pop);
    w_st_nx  = w_pop ? S_SETUP :
               ((r_st == S_SETUP) & w_ph_end) ? S_XFER :
               w_x_end ? S_HOLD :
               ((r_st == S_HOLD) & w_ph_end) ? S_GAP :
               ((r_st == S_GAP) & w_ph_end) ? S_IDLE : r_st;
  end
  always_ff @(posedge Clk)
    if (w_push) r_mem[r_wp] <= {Cmd_RA, Cmd_WnR, Cmd_DI};
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
      r_rdy <= 1'b1;
      r_st  <= S_IDLE;
      r_ph  <= '0;
      r_bit <= '0;
      r_ra  <= '0;
      r_wnr <= 1'b0;
      r_di  <= '0;
      r_do  <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
        {r_ra, r_wnr, r_di} <= r_mem[r_rp];
      end
      r_cnt <= w_cnt_nx;
      // ready is derived from the post-update count so a full queue can never accept
      r_rdy <= w_cnt_nx != FULL;
      r_st  <= w_st_nx;
      r_ph  <= ((w_st_nx != r_st) || w_ph_end) ? '0 : r_ph + 1'b1;
      r_bit <= (w_st_nx != r_st) ? '0 : ((r_st == S_XFER) && w_ph_end) ? r_bit + 1'b1 : r_bit;
      if (w_x_end) r_do <= r_wnr ? '0 : SSP_DO;
    end
  end
  always_comb begin
    w_sel    = (r_st == S_SETUP) | (r_st == S_XFER) | (r_st == S_HOLD);
    Cmd_Rdy  = r_rdy;
    SSP_SSEL = w_sel;
    SSP_RA   = w_sel ? r_ra : 3'd0;
    SSP_WnR  = w_sel & r_wnr;
    SSP_DI   = w_sel ? r_di : 12'd0;
    SSP_En   = r_st == S_XFER;
    SSP_SCK  = SSP_En & (r_ph < PH_HI);
    SSP_EOC  = SSP_En & (r_bit == 4'd11);
    Rsp_Vld  = (r_st == S_GAP) & (r_ph == '0);
    Rsp_RA   = Rsp_Vld ? r_ra : 3'd0;
    Rsp_WnR  = Rsp_Vld & r_wnr;
    Rsp_DO   = Rsp_Vld ? r_do : 12'd0;
    Busy     = (r_st != S_IDLE) | (r_cnt != '0);
  end
endmodule

// File: tb/tb_ssp_uart_cfg_seq.sv
// tb_ssp_uart_cfg_seq: directed vector table plus hand-written queue, burst and reset sequences
module tb_ssp_uart_cfg_seq;
  logic        Clk = 1'b0, Rst = 1'b1;
  logic        Cmd_Vld = 1'b0, Cmd_Rdy;
  logic [2:0]  Cmd_RA = '0;
  logic        Cmd_WnR = 1'b0;
  logic [11:0] Cmd_DI = '0;
  logic        SSP_SSEL, SSP_SCK, SSP_WnR, SSP_En, SSP_EOC;
  logic [2:0]  SSP_RA;
  logic [11:0] SSP_DI, SSP_DO = '0;
  logic        Rsp_Vld, Rsp_WnR, Busy;
  logic [2:0]  Rsp_RA;
  logic [11:0] Rsp_DO;

  ssp_uart_cfg_seq #(.CLK_DIV(2), .DEPTH(4)) dut (
    .Clk(Clk), .Rst(Rst), .Cmd_Vld(Cmd_Vld), .Cmd_Rdy(Cmd_Rdy), .Cmd_RA(Cmd_RA),
    .Cmd_WnR(Cmd_WnR), .Cmd_DI(Cmd_DI), .SSP_SSEL(SSP_SSEL), .SSP_SCK(SSP_SCK),
    .SSP_RA(SSP_RA), .SSP_WnR(SSP_WnR), .SSP_En(SSP_En), .SSP_EOC(SSP_EOC),
    .SSP_DI(SSP_DI), .SSP_DO(SSP_DO), .Rsp_Vld(Rsp_Vld), .Rsp_RA(Rsp_RA),
    .Rsp_WnR(Rsp_WnR), .Rsp_DO(Rsp_DO), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0]  ra;
    logic        wnr;
    logic [11:0] di;
    logic [11:0] din;
    logic [11:0] exp_do;
  } vec_t;
  vec_t vt[6];

  int n_cmp = 0, n_err = 0;
  int cyc = 0, push_cyc = 0;
  int sel_n, en_n, eoc_n, sckh_n, sckr_n, first_eoc, last_eoc, last_en, eoc_bad, bad;
  bit rdy_low, p_sel = 0, p_sck = 0, chk_f = 0, ok;
  logic [2:0]  e_ra;
  logic        e_wnr;
  logic [11:0] e_di;
  logic [15:0] rsp_q[$];
  int          rise_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic clear();
    sel_n = 0; en_n = 0; eoc_n = 0; sckh_n = 0; sckr_n = 0;
    first_eoc = 0; last_eoc = 0; last_en = 0; eoc_bad = 0; bad = 0; rdy_low = 0;
    rsp_q.delete();
    rise_q.delete();
  endtask

  task automatic step();
    @(negedge Clk);
    cyc++;
    if (!Cmd_Rdy) rdy_low = 1;
    if (Rsp_Vld) rsp_q.push_back({Rsp_RA, Rsp_WnR, Rsp_DO});
    if (SSP_SSEL && !p_sel) rise_q.push_back(cyc);
    if (SSP_SSEL) sel_n++;
    if (SSP_En) begin en_n++; last_en = cyc; end
    if (SSP_EOC) begin
      eoc_n++;
      if (first_eoc == 0) first_eoc = cyc;
      last_eoc = cyc;
      if (!SSP_En) eoc_bad++;
    end
    if (SSP_SCK) begin sckh_n++; if (!p_sck) sckr_n++; end
    if (SSP_SCK && !SSP_En) bad++;
    if (!SSP_SSEL && (SSP_En || SSP_SCK || SSP_EOC || SSP_RA != 0 || SSP_WnR || SSP_DI != 0)) bad++;
    if (SSP_SSEL && chk_f && (SSP_RA !== e_ra || SSP_WnR !== e_wnr || (e_wnr && SSP_DI !== e_di))) bad++;
    p_sel = SSP_SSEL;
    p_sck = SSP_SCK;
  endtask

  task automatic push(input logic [2:0] ra, input logic wnr, input logic [11:0] di);
    int t;
    Cmd_RA = ra; Cmd_WnR = wnr; Cmd_DI = di; Cmd_Vld = 1'b1; t = 0;
    do begin ok = Cmd_Rdy; step(); t++; end while (!ok && t < 300);
    Cmd_Vld = 1'b0;
    push_cyc = cyc;
    chk("push_accept", 32'(ok), 1);
  endtask

  function automatic logic [31:0] bus();
    return 32'({SSP_SSEL, SSP_SCK, SSP_RA, SSP_WnR, SSP_En, SSP_EOC, SSP_DI, Rsp_Vld, Rsp_RA, Rsp_WnR, Busy});
  endfunction

  initial begin
    int t;
    vt[0] = '{3'd3, 1'b1, 12'hA5C, 12'h000, 12'h000};
    vt[1] = '{3'd5, 1'b0, 12'h000, 12'h3F1, 12'h3F1};
    vt[2] = '{3'd0, 1'b1, 12'hFFF, 12'h555, 12'h000};
    vt[3] = '{3'd7, 1'b0, 12'h123, 12'hFFF, 12'hFFF};
    vt[4] = '{3'd1, 1'b1, 12'h001, 12'hABC, 12'h000};
    vt[5] = '{3'd2, 1'b0, 12'h800, 12'h000, 12'h000};
    clear();
    repeat (3) step();
    chk("rst_bus", bus(), 0);
    chk("rst_rdy", 32'(Cmd_Rdy), 1);
    Rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("idle_bus", bus(), 0);
      chk("idle_rdy", 32'(Cmd_Rdy), 1);
    end
    chk("idle_rsp_cnt", 32'(rsp_q.size()), 0);

    chk_f = 1;
    for (int i = 0; i < 6; i++) begin
      clear();
      e_ra = vt[i].ra; e_wnr = vt[i].wnr; e_di = vt[i].di;
      SSP_DO = vt[i].din;
      push(vt[i].ra, vt[i].wnr, vt[i].di);
      repeat (75) step();
      chk("ssel_rise", 32'(rise_q.size() > 0 ? rise_q[0] : 0), 32'(push_cyc + 1));
      chk("ssel_len", 32'(sel_n), 56);
      chk("en_len", 32'(en_n), 48);
      chk("sck_pulses", 32'(sckr_n), 12);
      chk("sck_high", 32'(sckh_n), 24);
      chk("eoc_len", 32'(eoc_n), 4);
      chk("eoc_pos", 32'(first_eoc), 32'(last_en - 3));
      chk("eoc_last", 32'(last_eoc), 32'(last_en));
      chk("eoc_outside_en", 32'(eoc_bad), 0);
      chk("frame_fields", 32'(bad), 0);
      chk("rsp_cnt", 32'(rsp_q.size()), 1);
      chk("rsp_val", 32'(rsp_q.size() > 0 ? rsp_q[0] : 16'hFFFF), 32'({vt[i].ra, vt[i].wnr, vt[i].exp_do}));
      chk("busy_end", 32'(Busy), 0);
    end

    chk_f = 0;
    clear();
    SSP_DO = 12'h7E7;
    for (int i = 0; i < 5; i++) push(3'(i + 1), i[0], 12'(12'h111 * i));
    repeat (330) step();
    chk("burst_rdy_low", 32'(rdy_low), 1);
    chk("burst_rsp_cnt", 32'(rsp_q.size()), 5);
    for (int i = 0; i < 5; i++)
      chk("burst_rsp", 32'(i < rsp_q.size() ? rsp_q[i] : 16'hFFFF), 32'({3'(i + 1), i[0], i[0] ? 12'h000 : 12'h7E7}));
    chk("burst_rises", 32'(rise_q.size()), 5);
    for (int i = 1; i < 5; i++)
      chk("burst_spacing", 32'(i < rise_q.size() ? rise_q[i] - rise_q[i-1] : 0), 61);
    chk("burst_ssel_total", 32'(sel_n), 280);
    chk("burst_fields", 32'(bad), 0);
    chk("burst_busy_end", 32'(Busy), 0);

    clear();
    SSP_DO = 12'h2C4;
    push(3'd1, 1'b1, 12'h111);
    push(3'd2, 1'b0, 12'h222);
    push(3'd3, 1'b1, 12'h333);
    t = 0;
    do begin step(); t++; end while (!Rsp_Vld && t < 100);
    chk("pp_first_rsp", 32'(Rsp_Vld), 1);
    repeat (4) step();
    chk("pp_idle_gap", 32'({SSP_SSEL, Rsp_Vld, Busy}), 32'(3'b001));
    push(3'd4, 1'b0, 12'h444);
    push(3'd5, 1'b1, 12'h555);
    chk("pp_rdy_before_full", 32'(Cmd_Rdy), 1);
    push(3'd6, 1'b0, 12'h666);
    chk("pp_rdy_full", 32'(Cmd_Rdy), 0);
    repeat (6 * 61 + 20) step();
    chk("pp_rsp_cnt", 32'(rsp_q.size()), 6);
    for (int i = 0; i < 6; i++)
      chk("pp_rsp", 32'(i < rsp_q.size() ? rsp_q[i] : 16'hFFFF),
          32'({3'(i + 1), ~i[0], i[0] ? 12'h2C4 : 12'h000}));
    chk("pp_fields", 32'(bad), 0);

    clear();
    push(3'd6, 1'b1, 12'hF0F);
    push(3'd2, 1'b0, 12'h000);
    push(3'd4, 1'b1, 12'h0F0);
    t = 0;
    while (!SSP_En && t < 50) begin step(); t++; end
    chk("rst_xfer_seen", 32'(SSP_En), 1);
    repeat (19) step();
    chk("rst_at_xfer20", 32'({SSP_En, SSP_SSEL}), 32'(2'b11));
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    chk("midrst_bus", bus(), 0);
    chk("midrst_rdy", 32'(Cmd_Rdy), 1);
    clear();
    repeat (100) step();
    chk("midrst_no_frames", 32'(rise_q.size()), 0);
    chk("midrst_no_rsp", 32'(rsp_q.size()), 0);
    chk("midrst_busy", 32'(Busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
